// File: rtl/verblur.sv
// Vertical 4-tap box blur over ARGB pixels in raster order; pairs with the
// horizontal blur upstream to give a 4x4 box blur on the write-back path.
module verblur #(
    parameter int IMG_WIDTH = 16,
    parameter int COL_W     = $clog2(IMG_WIDTH)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [2:0]       mode_wb,
    input  logic             wb_en,
    input  logic             clear,
    input  logic [31:0]      data,
    output logic [31:0]      blur,
    output logic [COL_W-1:0] col_idx,
    output logic             line_end
);

    localparam logic [2:0]       MODE_BLUR = 3'b101;
    localparam logic [COL_W-1:0] LAST_COL  = COL_W'(IMG_WIDTH - 1);

    logic [23:0]      h0 [IMG_WIDTH];
    logic [23:0]      h1 [IMG_WIDTH];
    logic [23:0]      h2 [IMG_WIDTH];
    logic [COL_W-1:0] col;
    logic             active;
    logic             commit;
    logic             unused_alpha;

    function automatic logic [7:0] avg4(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c, input logic [7:0] d);
        logic [9:0] sum;
        sum = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
        return sum[9:2];
    endfunction

    assign active       = (mode_wb == MODE_BLUR);
    assign commit       = active && wb_en && !clear;
    assign col_idx      = col;
    assign unused_alpha = &data[31:24];

    // Zero latency: blur is a pure function of data and the history at col.
    always_comb begin
        blur = {8'hff, data[23:0]};
        if (active) begin
            blur = {8'hff,
                    avg4(data[23:16], h0[col][23:16], h1[col][23:16], h2[col][23:16]),
                    avg4(data[15:8],  h0[col][15:8],  h1[col][15:8],  h2[col][15:8]),
                    avg4(data[7:0],   h0[col][7:0],   h1[col][7:0],   h2[col][7:0])};
        end
    end

    // History is cleared too: zero rows act as padding above the first line.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int c = 0; c < IMG_WIDTH; c++) begin
                h0[c] <= '0;
                h1[c] <= '0;
                h2[c] <= '0;
            end
            col      <= '0;
            line_end <= 1'b0;
        end else if (clear) begin
            for (int c = 0; c < IMG_WIDTH; c++) begin
                h0[c] <= '0;
                h1[c] <= '0;
                h2[c] <= '0;
            end
            col      <= '0;
            line_end <= 1'b0;
        end else begin
            line_end <= 1'b0;
            if (commit) begin
                h2[col]  <= h1[col];
                h1[col]  <= h0[col];
                h0[col]  <= data[23:0];
                col      <= (col == LAST_COL) ? '0 : col + 1'b1;
                line_end <= (col == LAST_COL);
            end
        end
    end

endmodule

// File: tb/tb_verblur.sv
// Directed bench for verblur at IMG_WIDTH=4 with hand-computed blur values.
module tb_verblur;

    localparam int W = 4;

    logic        clk;
    logic        n_rst;
    logic [2:0]  mode_wb;
    logic        wb_en;
    logic        clear;
    logic [31:0] data;
    logic [31:0] blur;
    logic [1:0]  col_idx;
    logic        line_end;

    int checks = 0;
    int errors = 0;

    verblur #(.IMG_WIDTH(W)) dut (
        .clk(clk), .n_rst(n_rst), .mode_wb(mode_wb), .wb_en(wb_en),
        .clear(clear), .data(data), .blur(blur), .col_idx(col_idx),
        .line_end(line_end)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic commit_row(input logic [31:0] px);
        data  = px;
        wb_en = 1'b1;
        repeat (W) tick();
        wb_en = 1'b0;
    endtask

    initial begin
        n_rst   = 1'b0;
        mode_wb = 3'b101;
        wb_en   = 1'b0;
        clear   = 1'b0;
        data    = 32'h0;
        #12;
        check("rst_blur", blur, 32'hff000000);
        check("rst_col", {30'd0, col_idx}, 32'd0);
        check("rst_le", {31'd0, line_end}, 32'd0);
        n_rst = 1'b1;
        tick();
        tick();
        check("post_rst_blur", blur, 32'hff000000);
        check("post_rst_col", {30'd0, col_idx}, 32'd0);
        check("post_rst_le", {31'd0, line_end}, 32'd0);

        // Fade-in over rows, plus column wrap and line_end pulse on row 1.
        data = 32'hffffffff;
        #1;
        check("fade_row0", blur, 32'hff3f3f3f);
        wb_en = 1'b1;
        for (int i = 1; i <= W; i++) begin
            tick();
            check($sformatf("wrap_col%0d", i), {30'd0, col_idx}, 32'(i % W));
            check($sformatf("wrap_le%0d", i), {31'd0, line_end}, {31'd0, (i == W)});
        end
        wb_en = 1'b0;
        check("fade_row1", blur, 32'hff7f7f7f);
        tick();
        check("le_drop", {31'd0, line_end}, 32'd0);
        commit_row(32'hffffffff);
        check("fade_row2", blur, 32'hffbfbfbf);
        commit_row(32'hffffffff);
        check("fade_row3", blur, 32'hffffffff);
        commit_row(32'hffffffff);
        check("fade_row4", blur, 32'hffffffff);

        // Mode gating mid-line at column 1.
        wb_en = 1'b1;
        tick();
        wb_en = 1'b0;
        check("gate_pre_col", {30'd0, col_idx}, 32'd1);
        mode_wb = 3'b000;
        data    = 32'h00123456;
        #1;
        check("gate_blur", blur, 32'hff123456);
        wb_en = 1'b1;
        tick();
        tick();
        wb_en = 1'b0;
        check("gate_col", {30'd0, col_idx}, 32'd1);
        check("gate_le", {31'd0, line_end}, 32'd0);
        mode_wb = 3'b101;
        data    = 32'h0;
        #1;
        check("gate_hist", blur, 32'hffbfbfbf);

        // Clear overrides a simultaneous strobe.
        data  = 32'hffffffff;
        wb_en = 1'b1;
        clear = 1'b1;
        tick();
        wb_en = 1'b0;
        clear = 1'b0;
        check("clr_col", {30'd0, col_idx}, 32'd0);
        check("clr_blur", blur, 32'hff3f3f3f);
        check("clr_le", {31'd0, line_end}, 32'd0);

        // Asynchronous reset mid-line.
        commit_row(32'hffffffff);
        commit_row(32'hffffffff);
        commit_row(32'hffffffff);
        wb_en = 1'b1;
        tick();
        tick();
        wb_en = 1'b0;
        check("mid_col", {30'd0, col_idx}, 32'd2);
        n_rst = 1'b0;
        #2;
        n_rst = 1'b1;
        #1;
        check("arst_col", {30'd0, col_idx}, 32'd0);
        check("arst_blur", blur, 32'hff3f3f3f);
        check("arst_le", {31'd0, line_end}, 32'd0);

        // Column independence.
        wb_en = 1'b1;
        for (int c = 0; c < W; c++) begin
            data = (c == 1) ? 32'h00404040 : 32'h0;
            tick();
        end
        wb_en = 1'b0;
        data  = 32'h0;
        for (int c = 0; c < W; c++) begin
            #1;
            check($sformatf("indep_col%0d", c), blur, (c == 1) ? 32'hff101010 : 32'hff000000);
            wb_en = 1'b1;
            tick();
            wb_en = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
